gate_deadtime: RTL and testbench

//  Downstream stage of the switch-sequencing FSM: takes its 6-bit switch request vector Sout
//  and drives the six gate outputs. Inserts a programmable turn-on dead time per switch.

---
 rtl/gate_deadtime_pkg.sv | 17 +
 rtl/gate_deadtime_channel.sv | 67 ++++++
 rtl/gate_deadtime.sv | 73 +++++++
 tb/tb_gate_deadtime.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_deadtime_pkg.sv
// Shared types and constants for the gate dead-time stage.
// Channel states, channel count and the pair-partner helper.
package gate_deadtime_pkg;

  localparam int NUM_CH = 6;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ON   = 2'd2
  } ch_state_e;

  function automatic int partner(input int i);
    return i ^ 1;
  endfunction

endpackage

// File: rtl/gate_deadtime_channel.sv
// One gate channel: OFF/WAIT/ON state, dead-time counter
// and the registered gate drive.
module gate_deadtime_channel
  import gate_deadtime_pkg::*;
#(
  parameter int DEADTIME = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic partner_idle,
  input  logic grant_block,
  input  logic kill,
  output logic gate,
  output logic waiting,
  output logic idle
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;

  // Channel sequencing: arm on request, count dead time, then drive.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state <= ST_OFF;
      cnt   <= '0;
      gate  <= 1'b0;
    end else begin
      unique case (state)
        ST_OFF: begin
          if (req && partner_idle && !grant_block) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(DEADTIME);
          end
        end
        ST_WAIT: begin
          if (!req || !partner_idle) begin
            state <= ST_OFF;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            state <= ST_ON;
            cnt   <= '0;
            gate  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ON: begin
          if (!req) begin
            state <= ST_OFF;
            gate  <= 1'b0;
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          gate  <= 1'b0;
        end
      endcase
    end
  end

  assign waiting = (state == ST_WAIT);
  assign idle    = (state == ST_OFF) && !gate;

endmodule

// File: rtl/gate_deadtime.sv
// Gate driver stage: per-switch dead time, pair interlock,
// even-wins arbitration and a sticky short-circuit fault.
module gate_deadtime
  import gate_deadtime_pkg::*;
#(
  parameter int DEADTIME = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] Sin,
  input  logic              Short,
  input  logic              fault_clr,
  output logic [NUM_CH-1:0] Gate,
  output logic              fault,
  output logic              busy,
  output logic              conflict
);

  logic [NUM_CH-1:0]   idle;
  logic [NUM_CH-1:0]   waiting;
  logic [NUM_CH-1:0]   blk;
  logic [NUM_CH/2-1:0] clash;

  // Even channel wins a simultaneous pair request; fault blocks all.
  always_comb begin
    blk   = {NUM_CH{fault}};
    clash = '0;
    for (int j = 0; j < NUM_CH/2; j++) begin
      clash[j] = Sin[2*j] & Sin[2*j+1]
               & idle[2*j] & idle[2*j+1];
      blk[2*j+1] = fault | (Sin[2*j] & idle[2*j]);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gate_deadtime_channel #(
      .DEADTIME(DEADTIME),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .req         (Sin[i]),
      .partner_idle(idle[partner(i)]),
      .grant_block (blk[i]),
      .kill        (Short),
      .gate        (Gate[i]),
      .waiting     (waiting[i]),
      .idle        (idle[i])
    );
  end

  // Sticky fault: set by Short, cleared only when Short is gone.
  always_ff @(posedge clk) begin
    if (rst)
      fault <= 1'b0;
    else if (Short)
      fault <= 1'b1;
    else if (fault_clr)
      fault <= 1'b0;
  end

  // One-cycle pulse when both members of a pair contend.
  always_ff @(posedge clk) begin
    if (rst)
      conflict <= 1'b0;
    else
      conflict <= (|clash) & ~fault & ~Short;
  end

  assign busy = |waiting;

endmodule

// File: tb/tb_gate_deadtime.sv
// Directed bench for gate_deadtime with DEADTIME=4.
// Hand-computed expectations, pair exclusion checked every cycle.
module tb_gate_deadtime;

  logic       clk;
  logic       rst;
  logic [5:0] Sin;
  logic       Short;
  logic       fault_clr;
  logic [5:0] Gate;
  logic       fault;
  logic       busy;
  logic       conflict;

  int total = 0;
  int bad   = 0;

  gate_deadtime #(.DEADTIME(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .Sin      (Sin),
    .Short    (Short),
    .fault_clr(fault_clr),
    .Gate     (Gate),
    .fault    (fault),
    .busy     (busy),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 3; j++)
        chk("excl", 32'(Gate[2*j] & Gate[2*j+1]), 32'd0);
    end
  end

  initial begin
    rst       = 1'b1;
    Sin       = 6'b000001;
    Short     = 1'b0;
    fault_clr = 1'b0;

    // reset held two cycles with a live request
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gate", 32'(Gate), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_conf", 32'(conflict), 32'h0);
    end
    Sin = 6'b000000;
    rst = 1'b0;
    step();
    chk("idle_gate", 32'(Gate), 32'h0);

    // turn-on latency and immediate turn-off
    Sin = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lat_gate", 32'(Gate), 32'h0);
      chk("lat_busy", 32'(busy), 32'h1);
    end
    step();
    chk("lat_on", 32'(Gate), 32'h01);
    chk("lat_busy0", 32'(busy), 32'h0);
    Sin = 6'b000000;
    step();
    chk("off_gate", 32'(Gate), 32'h0);

    // hand-over 0 -> 1
    Sin = 6'b000001;
    step(4);
    step();
    chk("ho_on0", 32'(Gate), 32'h01);
    Sin = 6'b000010;
    step();
    chk("ho_drop", 32'(Gate), 32'h00);
    chk("ho_busy0", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ho_wait", 32'(Gate), 32'h00);
      chk("ho_busy", 32'(busy), 32'h1);
    end
    step();
    chk("ho_on1", 32'(Gate), 32'h02);
    Sin = 6'b000000;
    step();
    chk("ho_off", 32'(Gate), 32'h00);

    // simultaneous pair request, even wins
    Sin = 6'b001100;
    step();
    chk("cf_pulse", 32'(conflict), 32'h1);
    chk("cf_busy", 32'(busy), 32'h1);
    step();
    chk("cf_clear", 32'(conflict), 32'h0);
    step(2);
    chk("cf_wait", 32'(Gate), 32'h00);
    step();
    chk("cf_on", 32'(Gate), 32'h04);
    step();
    chk("cf_hold", 32'(Gate), 32'h04);
    Sin = 6'b000000;
    step();
    chk("cf_off", 32'(Gate), 32'h00);

    // short-circuit fault and recovery
    Sin = 6'b010101;
    step(4);
    chk("ft_pre", 32'(Gate), 32'h00);
    step();
    chk("ft_on", 32'(Gate), 32'h15);
    Short = 1'b1;
    step();
    chk("ft_gate", 32'(Gate), 32'h00);
    chk("ft_set", 32'(fault), 32'h1);
    chk("ft_busy", 32'(busy), 32'h0);
    fault_clr = 1'b1;
    step();
    chk("ft_clr_ign", 32'(fault), 32'h1);
    Short     = 1'b0;
    fault_clr = 1'b0;
    step();
    chk("ft_sticky", 32'(fault), 32'h1);
    chk("ft_blk", 32'(busy), 32'h0);
    fault_clr = 1'b1;
    step();
    chk("ft_clr", 32'(fault), 32'h0);
    chk("ft_clr_busy", 32'(busy), 32'h0);
    fault_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ft_rewait", 32'(Gate), 32'h00);
      chk("ft_rebusy", 32'(busy), 32'h1);
    end
    step();
    chk("ft_reon", 32'(Gate), 32'h15);
    Sin = 6'b000000;
    step();
    chk("ft_off", 32'(Gate), 32'h00);

    // reset in the middle of a dead-time count
    Sin = 6'b000001;
    step(3);
    chk("mr_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    step();
    chk("mr_gate", 32'(Gate), 32'h00);
    chk("mr_busy0", 32'(busy), 32'h0);
    chk("mr_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_wait", 32'(Gate), 32'h00);
    end
    step();
    chk("mr_on", 32'(Gate), 32'h01);
    Sin = 6'b000000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
